// File: rtl/stream_hasher_pkg.sv
// Shared types and constants for the streaming hasher.
package stream_hasher_pkg;

  typedef enum logic [1:0] {IDLE, ROUND, DONE} state_e;

  localparam logic [31:0] DEFAULT_IV = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_K  = 32'h9E37_79B9;

  // Width of in_len: enough to encode 0..DATA_W/8 inclusive.
  function automatic int len_width(input int data_w);
    return $clog2(data_w / 8) + 1;
  endfunction

endpackage

// File: rtl/stream_hasher_rotator.sv
// Constant-distance barrel rotator; LEFT selects rotate direction.
module stream_hasher_rotator
  import stream_hasher_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter bit LEFT  = 1'b1,
  parameter int DIST  = 0
) (
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  localparam int D = DIST % WIDTH;

  generate
    if (D == 0) begin : g_pass
      assign dout = din;
    end else if (LEFT) begin : g_left
      assign dout = {din[WIDTH-D-1:0], din[WIDTH-1:WIDTH-D]};
    end else begin : g_right
      assign dout = {din[D-1:0], din[WIDTH-1:D]};
    end
  endgenerate

endmodule

// File: rtl/stream_hasher.sv
// Multi-cycle rotate-add streaming hasher with valid/ready chunk input and digest output.
// Define STREAM_HASHER_LEN_FINAL_EN to fold the total byte count into the final digest.
module stream_hasher
  import stream_hasher_pkg::*;
#(
  parameter int               WIDTH     = 32,
  parameter int               DATA_W    = 64,
  parameter int               ROUNDS    = 4,
  parameter int               ROT       = 5,
  parameter logic [WIDTH-1:0] IV        = WIDTH'(DEFAULT_IV),
  parameter logic [WIDTH-1:0] K         = WIDTH'(DEFAULT_K),
  parameter int               LEN_CNT_W = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [DATA_W-1:0]             in_data,
  input  logic [len_width(DATA_W)-1:0]  in_len,
  input  logic                          in_last,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [WIDTH-1:0]              out_hash
);

  localparam int              LEN_W  = len_width(DATA_W);
  localparam int              NBYTES = DATA_W / 8;
  localparam int              NSLICE = DATA_W / WIDTH;
  localparam logic [LEN_W-1:0] NB_L  = LEN_W'(NBYTES);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] h_q, h_d;
  logic [7:0]       round_q, round_d;
  logic             last_q, last_d;
  logic [WIDTH-1:0] out_hash_q, out_hash_d;
`ifdef STREAM_HASHER_LEN_FINAL_EN
  logic [LEN_CNT_W-1:0] byte_cnt_q, byte_cnt_d;
`endif

  logic [LEN_W-1:0]  len_clamped;
  logic [DATA_W-1:0] masked;
  logic [WIDTH-1:0]  fold;
  logic [WIDTH-1:0]  rot_out;
  logic [WIDTH-1:0]  a_next;
  logic [WIDTH-1:0]  final_hash;

  stream_hasher_rotator #(
    .WIDTH (WIDTH),
    .LEFT  (1'b1),
    .DIST  (ROT)
  ) u_rotator (
    .din  (a_q),
    .dout (rot_out)
  );

  // Byte masking and XOR fold of the incoming chunk down to WIDTH bits.
  always_comb begin
    len_clamped = (in_len > NB_L) ? NB_L : in_len;
    masked      = '0;
    for (int i = 0; i < NBYTES; i++) begin
      if (LEN_W'(i) < len_clamped) masked[i*8 +: 8] = in_data[i*8 +: 8];
    end
    fold = '0;
    for (int s = 0; s < NSLICE; s++) begin
      fold = fold ^ masked[s*WIDTH +: WIDTH];
    end
    a_next = rot_out + K + WIDTH'(round_q);
`ifdef STREAM_HASHER_LEN_FINAL_EN
    final_hash = a_next ^ WIDTH'(byte_cnt_q);
`else
    final_hash = a_next;
`endif
  end

  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    h_d        = h_q;
    round_d    = round_q;
    last_d     = last_q;
    out_hash_d = out_hash_q;
`ifdef STREAM_HASHER_LEN_FINAL_EN
    byte_cnt_d = byte_cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = h_q ^ fold;
          round_d = '0;
          last_d  = in_last;
`ifdef STREAM_HASHER_LEN_FINAL_EN
          byte_cnt_d = byte_cnt_q + LEN_CNT_W'(len_clamped);
`endif
          state_d = ROUND;
        end
      end
      ROUND: begin
        if (round_q == 8'(ROUNDS - 1)) begin
          h_d     = a_next;
          round_d = '0;
          if (last_q) begin
            out_hash_d = final_hash;
            state_d    = DONE;
          end else begin
            state_d = IDLE;
          end
        end else begin
          a_d     = a_next;
          round_d = round_q + 8'd1;
        end
      end
      DONE: begin
        if (out_ready) begin
          h_d = IV;
`ifdef STREAM_HASHER_LEN_FINAL_EN
          byte_cnt_d = '0;
`endif
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      a_q        <= '0;
      h_q        <= IV;
      round_q    <= '0;
      last_q     <= 1'b0;
      out_hash_q <= '0;
`ifdef STREAM_HASHER_LEN_FINAL_EN
      byte_cnt_q <= '0;
`endif
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      h_q        <= h_d;
      round_q    <= round_d;
      last_q     <= last_d;
      out_hash_q <= out_hash_d;
`ifdef STREAM_HASHER_LEN_FINAL_EN
      byte_cnt_q <= byte_cnt_d;
`endif
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign out_hash  = out_hash_q;

endmodule

// File: tb/tb_stream_hasher.sv
// Scoreboard testbench for stream_hasher: directed vectors plus randomized messages
// checked against a behavioural model of the hash rules.
module tb_stream_hasher;

  localparam int          WIDTH     = 32;
  localparam int          DATA_W    = 64;
  localparam int          ROUNDS    = 1;
  localparam int          ROT       = 5;
  localparam logic [31:0] IV        = 32'h0000_0000;
  localparam logic [31:0] K         = 32'h9E37_79B9;
  localparam int          LEN_CNT_W = 16;

`ifdef STREAM_HASHER_LEN_FINAL_EN
  localparam logic [31:0] EXP_BYTE1 = 32'h9E37_79D8;
  localparam logic [31:0] EXP_MASK2 = 32'h9E57_799B;
  localparam logic [31:0] EXP_MASK8 = 32'h9E37_79B1;
`else
  localparam logic [31:0] EXP_BYTE1 = 32'h9E37_79D9;
  localparam logic [31:0] EXP_MASK2 = 32'h9E57_7999;
  localparam logic [31:0] EXP_MASK8 = 32'h9E37_79B9;
`endif
  localparam logic [31:0] EXP_EMPTY = 32'h9E37_79B9;
  localparam logic [31:0] EXP_MULTI = 32'h6526_B0EC;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_data;
  logic [3:0]  in_len;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_hash;

  int checks = 0;
  int errors = 0;
  int readyMode = 1;
  logic [31:0] expQ[$];
  logic [31:0] mH;
  logic [15:0] mCnt;

  stream_hasher #(
    .WIDTH     (WIDTH),
    .DATA_W    (DATA_W),
    .ROUNDS    (ROUNDS),
    .ROT       (ROT),
    .IV        (IV),
    .K         (K),
    .LEN_CNT_W (LEN_CNT_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_len    (in_len),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_hash  (out_hash)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Reference: mask to the valid bytes, XOR the 32-bit words, then apply each rotate-add round.
  function automatic logic [31:0] modelChunk(input logic [31:0] h, input logic [63:0] data,
                                             input int len);
    int          n;
    logic [63:0] m;
    logic [31:0] a;
    n = (len > 8) ? 8 : len;
    m = '0;
    for (int i = 0; i < n; i++) m[i*8 +: 8] = data[i*8 +: 8];
    a = h ^ m[31:0] ^ m[63:32];
    for (int r = 0; r < ROUNDS; r++) a = {a[31-ROT:0], a[31:32-ROT]} + K + 32'(r);
    return a;
  endfunction

  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      case (readyMode)
        0:       out_ready = 1'b0;
        1:       out_ready = 1'b1;
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: every accepted digest is popped from the scoreboard and compared.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpectedHash", out_hash, 32'hxxxx_xxxx);
      end else begin
        checkOutput("hash", out_hash, expQ.pop_front());
      end
    end
  end

  task automatic applyStimulus(input logic [63:0] data, input logic [3:0] len, input logic last,
                               input bit useConst, input logic [31:0] constHash);
    int          waitCycles;
    int          n;
    logic [31:0] finalHash;
    waitCycles = 0;
    @(negedge clk);
    in_data  = data;
    in_len   = len;
    in_last  = last;
    in_valid = 1'b1;
    while (!in_ready && waitCycles < 200) begin
      @(negedge clk);
      waitCycles++;
    end
    if (!in_ready) begin
      checkOutput("inReadyTimeout", {31'b0, in_ready}, 32'd1);
      in_valid = 1'b0;
    end else begin
      n    = (len > 8) ? 8 : int'(len);
      mH   = modelChunk(mH, data, int'(len));
      mCnt = mCnt + 16'(n);
      if (last) begin
`ifdef STREAM_HASHER_LEN_FINAL_EN
        finalHash = mH ^ {16'b0, mCnt};
`else
        finalHash = mH;
`endif
        expQ.push_back(useConst ? constHash : finalHash);
        mH   = IV;
        mCnt = '0;
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
    end
  endtask

  task automatic waitDrain();
    int c;
    c = 0;
    while ((expQ.size() != 0 || out_valid) && c < 500) begin
      @(posedge clk);
      #1;
      c++;
    end
    checkOutput("drain", 32'(expQ.size()), 32'd0);
  endtask

  initial begin
    logic [31:0] held;
    bit          sawValid;
    int          nChunks;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    in_len   = '0;
    in_last  = 1'b0;
    mH       = IV;
    mCnt     = '0;
    #12;
    checkOutput("resetInReady", {31'b0, in_ready}, 32'd1);
    checkOutput("resetOutValid", {31'b0, out_valid}, 32'd0);
    checkOutput("resetOutHash", out_hash, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Empty message with latency check
    applyStimulus(64'h0, 4'd0, 1'b1, 1'b1, EXP_EMPTY);
    checkOutput("roundInReady", {31'b0, in_ready}, 32'd0);
    checkOutput("roundOutValid", {31'b0, out_valid}, 32'd0);
    @(posedge clk);
    #1;
    checkOutput("latencyOutValid", {31'b0, out_valid}, 32'd1);
    @(posedge clk);
    #1;
    checkOutput("handoffOutValid", {31'b0, out_valid}, 32'd0);
    checkOutput("handoffInReady", {31'b0, in_ready}, 32'd1);

    applyStimulus(64'h1, 4'd1, 1'b1, 1'b1, EXP_BYTE1);
    applyStimulus(64'hFFFF_FFFF_FFFF_FFFF, 4'd2, 1'b1, 1'b1, EXP_MASK2);
    applyStimulus(64'hFFFF_FFFF_FFFF_FFFF, 4'd8, 1'b1, 1'b1, EXP_MASK8);
    applyStimulus(64'hFFFF_FFFF_FFFF_FFFF, 4'd15, 1'b1, 1'b1, EXP_MASK8);
    applyStimulus(64'h0, 4'd0, 1'b0, 1'b0, 32'h0);
    checkOutput("multiRoundInReady", {31'b0, in_ready}, 32'd0);
    applyStimulus(64'h0, 4'd0, 1'b1, 1'b1, EXP_MULTI);
    waitDrain();

    // Back-pressure: digest must hold while out_ready stays low
    readyMode = 0;
    @(posedge clk);
    #3;
    applyStimulus(64'h0, 4'd0, 1'b1, 1'b1, EXP_EMPTY);
    for (int c = 0; c < 20 && !out_valid; c++) begin
      @(posedge clk);
      #1;
    end
    held = out_hash;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1;
      checkOutput("bpOutValid", {31'b0, out_valid}, 32'd1);
      checkOutput("bpOutHash", out_hash, held);
      checkOutput("bpInReady", {31'b0, in_ready}, 32'd0);
    end
    readyMode = 1;
    waitDrain();
    applyStimulus(64'h0, 4'd0, 1'b1, 1'b1, EXP_EMPTY);
    waitDrain();

    // Asynchronous reset in the middle of a round
    applyStimulus(64'h1234_5678_9ABC_DEF0, 4'd8, 1'b1, 1'b0, 32'h0);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("midResetInReady", {31'b0, in_ready}, 32'd1);
    checkOutput("midResetOutValid", {31'b0, out_valid}, 32'd0);
    checkOutput("midResetOutHash", out_hash, 32'd0);
    expQ.delete();
    mH   = IV;
    mCnt = '0;
    @(negedge clk);
    rst_n = 1'b1;
    sawValid = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      if (out_valid) sawValid = 1'b1;
    end
    checkOutput("noValidAfterReset", {31'b0, sawValid}, 32'd0);
    applyStimulus(64'h0, 4'd0, 1'b1, 1'b1, EXP_EMPTY);
    waitDrain();

    // Randomized messages with random consumer back-pressure
    readyMode = 2;
    for (int m = 0; m < 40; m++) begin
      nChunks = $urandom_range(1, 4);
      for (int c = 0; c < nChunks; c++) begin
        applyStimulus({$urandom, $urandom}, 4'($urandom_range(0, 15)), (c == nChunks - 1),
                      1'b0, 32'h0);
      end
    end
    waitDrain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
